renderer_rect_blend_engine: RTL and testbench

//  Parametrised successor of the per-command rectangle renderer. Walks a latched rectangle
//  (x1..x2, y1..y2) pixel by pixel and writes it to the selected VRAM bank. Opaque colours
//  (alpha = max) are written directly; translucent colours use a read-blend-write cycle.

---
 rtl/renderer_rect_blend_engine_if.sv | 35 +++
 rtl/renderer_rect_blend_engine.sv | 215 +++++++++++++++++++++
 tb/tb_renderer_rect_blend_engine.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/renderer_rect_blend_engine_if.sv
// VRAM access bus between the rectangle renderer (master) and the VRAM
// controller (slave). Two independent request/strobe channels:
//   read : o_vram_read_address, o_vram_read_request  -> controller
//          i_vram_read_data, i_vram_read_data_valid  <- controller
//   write: o_vram_write_address, o_vram_write_data,
//          o_vram_write_request                      -> controller
//          i_vram_write_done                         <- controller
// Requests are level signals held until the matching 1-cycle strobe.
interface renderer_rect_blend_engine_if #(
  parameter int ADDR_W  = 20,
  parameter int PIXEL_W = 12
);
  logic [ADDR_W-1:0]  o_vram_read_address;
  logic               o_vram_read_request;
  logic [PIXEL_W-1:0] i_vram_read_data;
  logic               i_vram_read_data_valid;
  logic [ADDR_W-1:0]  o_vram_write_address;
  logic [PIXEL_W-1:0] o_vram_write_data;
  logic               o_vram_write_request;
  logic               i_vram_write_done;

  modport master (
    output o_vram_read_address, o_vram_read_request,
    input  i_vram_read_data, i_vram_read_data_valid,
    output o_vram_write_address, o_vram_write_data, o_vram_write_request,
    input  i_vram_write_done
  );

  modport slave (
    input  o_vram_read_address, o_vram_read_request,
    output i_vram_read_data, i_vram_read_data_valid,
    input  o_vram_write_address, o_vram_write_data, o_vram_write_request,
    output i_vram_write_done
  );
endinterface

// File: rtl/renderer_rect_blend_engine.sv
// Rectangle renderer with alpha blend. Walks a latched rectangle (x1..x2,
// y1..y2, inclusive) row by row and writes each pixel to the selected VRAM
// bank. Opaque colour (alpha all-ones) is written directly; any other alpha
// uses read -> blend -> write per pixel. One command in flight at a time.
//
// Ports:
//   i_master_clk, i_reset        clock, synchronous active-high reset
//   i_process_start/_bank        1-cycle start pulse, target bank (latched)
//   o_process_busy/_finished     busy level, 1-cycle completion pulse
//   i_cmd_rect_x1/x2/y1/y2       rectangle corners (latched on start)
//   i_cmd_color_red/green/blue   source colour     (latched on start)
//   i_cmd_color_alpha            source alpha      (latched on start)
//   vram                         VRAM bus, master side
//
// Optional feature: define RENDERER_CLIP_EN to clamp the rectangle to
// SCREEN_W x SCREEN_H and drop rectangles that start off-screen.
//
// state   | meaning
// S_IDLE  | waiting for i_process_start
// S_SETUP | clamp/validate rectangle, issue first pixel
// S_READ  | read request held until read data valid
// S_BLEND | blended pixel registered, raise write request
// S_WRITE | write request held until write done
// S_NEXT  | advance x/y (request gap cycle), issue next pixel or finish
// S_DONE  | finished pulse cycle, back to idle
module renderer_rect_blend_engine #(
  parameter int COORD_W     = 10,
  parameter int COLOR_W     = 4,
  parameter int ADDR_W      = 20,
  parameter int LINE_STRIDE = 480,
  parameter int BANK_OFFSET = 'h40000,
  parameter int SCREEN_W    = 480,
  parameter int SCREEN_H    = 272
) (
  input  logic               i_master_clk,
  input  logic               i_reset,
  input  logic               i_process_start,
  input  logic               i_process_bank,
  output logic               o_process_busy,
  output logic               o_process_finished,
  input  logic [COORD_W-1:0] i_cmd_rect_x1,
  input  logic [COORD_W-1:0] i_cmd_rect_x2,
  input  logic [COORD_W-1:0] i_cmd_rect_y1,
  input  logic [COORD_W-1:0] i_cmd_rect_y2,
  input  logic [COLOR_W-1:0] i_cmd_color_red,
  input  logic [COLOR_W-1:0] i_cmd_color_green,
  input  logic [COLOR_W-1:0] i_cmd_color_blue,
  input  logic [COLOR_W-1:0] i_cmd_color_alpha,
  renderer_rect_blend_engine_if.master vram
);
  localparam int PIXEL_W = 3 * COLOR_W;
  localparam int ACC_W   = 2 * COLOR_W + 1;
  localparam int HALF    = 2 ** (COLOR_W - 1);
  localparam logic [COLOR_W-1:0] ALPHA_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_READ, S_BLEND, S_WRITE, S_NEXT, S_DONE
  } state_t;

  state_t             state;
  logic               busy_q, fin_q, rd_req_q, wr_req_q, bank_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [PIXEL_W-1:0] wr_data_q, color_q;
  logic [COLOR_W-1:0] alpha_q;
  logic [COORD_W-1:0] x_q, y_q, x1_q, x2_q, y1_q, y2_q;

  logic [COORD_W-1:0] x2_eff, y2_eff, px, py;
  logic               outside, stop;

  // Address arithmetic is done directly in ADDR_W bits, which gives the
  // modulo-2^ADDR_W wrap for free.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic bank,
                                                 input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    pix_addr = (bank ? ADDR_W'(BANK_OFFSET) : '0)
             + ADDR_W'(y) * ADDR_W'(LINE_STRIDE) + ADDR_W'(x);
  endfunction

  // Alpha 0 is special-cased: the rounding term would otherwise darken a
  // fully-on channel by one step.
  function automatic logic [PIXEL_W-1:0] blend_px(input logic [PIXEL_W-1:0] src,
                                                  input logic [PIXEL_W-1:0] dst,
                                                  input logic [COLOR_W-1:0] a);
    logic [ACC_W-1:0]   acc;
    logic [COLOR_W-1:0] c, o;
    blend_px = dst;
    if (a != '0) begin
      for (int i = 0; i < 3; i++) begin
        c   = src[i*COLOR_W +: COLOR_W];
        o   = dst[i*COLOR_W +: COLOR_W];
        acc = ACC_W'(c) * ACC_W'(a) + ACC_W'(o) * ACC_W'(ALPHA_MAX - a) + ACC_W'(HALF);
        blend_px[i*COLOR_W +: COLOR_W] = COLOR_W'(acc >> COLOR_W);
      end
    end
  endfunction

  always_comb begin
`ifdef RENDERER_CLIP_EN
    outside = (int'(x1_q) >= SCREEN_W) || (int'(y1_q) >= SCREEN_H);
    x2_eff  = (int'(x2_q) >= SCREEN_W) ? COORD_W'(SCREEN_W - 1) : x2_q;
    y2_eff  = (int'(y2_q) >= SCREEN_H) ? COORD_W'(SCREEN_H - 1) : y2_q;
`else
    outside = 1'b0;
    x2_eff  = x2_q;
    y2_eff  = y2_q;
`endif
    // SETUP stops on an empty rectangle, NEXT stops after the last pixel.
    if (state == S_SETUP) begin
      stop = outside || (x1_q > x2_eff) || (y1_q > y2_eff);
      px   = x1_q;
      py   = y1_q;
    end else begin
      stop = (x_q == x2_q) && (y_q == y2_q);
      if (x_q == x2_q) begin
        px = x1_q;
        py = y_q + COORD_W'(1);
      end else begin
        px = x_q + COORD_W'(1);
        py = y_q;
      end
    end
  end

  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      bank_q    <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      color_q   <= '0;
      alpha_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_process_start) begin
            x1_q    <= i_cmd_rect_x1;
            x2_q    <= i_cmd_rect_x2;
            y1_q    <= i_cmd_rect_y1;
            y2_q    <= i_cmd_rect_y2;
            color_q <= {i_cmd_color_red, i_cmd_color_green, i_cmd_color_blue};
            alpha_q <= i_cmd_color_alpha;
            bank_q  <= i_process_bank;
            busy_q  <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP, S_NEXT: begin
          if (state == S_SETUP) begin
            x2_q <= x2_eff;
            y2_q <= y2_eff;
          end
          if (stop) begin
            fin_q  <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end else begin
            x_q    <= px;
            y_q    <= py;
            addr_q <= pix_addr(bank_q, px, py);
            if (alpha_q == ALPHA_MAX) begin
              wr_data_q <= color_q;
              wr_req_q  <= 1'b1;
              state     <= S_WRITE;
            end else begin
              rd_req_q <= 1'b1;
              state    <= S_READ;
            end
          end
        end
        S_READ: begin
          if (rd_req_q && vram.i_vram_read_data_valid) begin
            rd_req_q  <= 1'b0;
            wr_data_q <= blend_px(color_q, vram.i_vram_read_data, alpha_q);
            state     <= S_BLEND;
          end
        end
        S_BLEND: begin
          wr_req_q <= 1'b1;
          state    <= S_WRITE;
        end
        S_WRITE: begin
          if (wr_req_q && vram.i_vram_write_done) begin
            wr_req_q <= 1'b0;
            state    <= S_NEXT;
          end
        end
        S_DONE: begin
          fin_q <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read and write never overlap on the same pixel, so one address register
  // serves both channels.
  assign vram.o_vram_read_address  = addr_q;
  assign vram.o_vram_read_request  = rd_req_q;
  assign vram.o_vram_write_address = addr_q;
  assign vram.o_vram_write_data    = wr_data_q;
  assign vram.o_vram_write_request = wr_req_q;
  assign o_process_busy            = busy_q;
  assign o_process_finished        = fin_q;
endmodule

// File: tb/tb_renderer_rect_blend_engine.sv
// Self-checking bench for renderer_rect_blend_engine: behavioural VRAM
// controller with random latency, a pixel-list reference model and a
// scoreboard of expected reads and writes.
module tb_renderer_rect_blend_engine;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 4;
  localparam int ADDR_W  = 20;
  localparam int PIXEL_W = 12;
  localparam int STRIDE  = 480;
  localparam int BANK1   = 'h40000;
  localparam int SCR_W   = 480;
  localparam int SCR_H   = 272;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, bank, busy, finished;
  logic [COORD_W-1:0] cx1, cx2, cy1, cy2;
  logic [COLOR_W-1:0] cr, cg, cb, ca;

  renderer_rect_blend_engine_if #(.ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W)) vif ();

  renderer_rect_blend_engine #(
    .COORD_W(COORD_W), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .LINE_STRIDE(STRIDE),
    .BANK_OFFSET(BANK1), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H)
  ) u_dut (
    .i_master_clk(clk), .i_reset(rst),
    .i_process_start(start), .i_process_bank(bank),
    .o_process_busy(busy), .o_process_finished(finished),
    .i_cmd_rect_x1(cx1), .i_cmd_rect_x2(cx2), .i_cmd_rect_y1(cy1), .i_cmd_rect_y2(cy2),
    .i_cmd_color_red(cr), .i_cmd_color_green(cg), .i_cmd_color_blue(cb),
    .i_cmd_color_alpha(ca),
    .vram(vif)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- memories and reference model ----------------
  logic [11:0] vram_mem [int];
  logic [11:0] ref_mem  [int];

  function automatic logic [11:0] seed_px(int a);
    return 12'((a * 37) ^ (a >> 3) ^ 'h5a5);
  endfunction

  function automatic logic [11:0] vram_get(int a);
    if (vram_mem.exists(a)) return vram_mem[a];
    return seed_px(a);
  endfunction

  function automatic logic [11:0] ref_get(int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return seed_px(a);
  endfunction

  function automatic int blend_ch(int c, int o, int a);
    if (a == 0) return o;
    return (c * a + o * (15 - a) + 8) / 16;
  endfunction

  typedef struct { int addr; logic [11:0] data; } wr_t;
  wr_t exp_wr[$];
  int  exp_rd[$];

  task automatic model_cmd(input int x1, input int x2, input int y1, input int y2,
                           input bit bnk, input logic [11:0] col, input int alpha);
    int xe, ye;
    xe = x2;
    ye = y2;
`ifdef RENDERER_CLIP_EN
    if (x1 >= SCR_W || y1 >= SCR_H) return;
    if (xe > SCR_W - 1) xe = SCR_W - 1;
    if (ye > SCR_H - 1) ye = SCR_H - 1;
`endif
    for (int y = y1; y <= ye; y++) begin
      for (int x = x1; x <= xe; x++) begin
        int a;
        logic [11:0] o, p;
        a = ((bnk ? BANK1 : 0) + y * STRIDE + x) % (1 << ADDR_W);
        if (alpha == 15) p = col;
        else begin
          o = ref_get(a);
          exp_rd.push_back(a);
          p = {4'(blend_ch(int'(col[11:8]), int'(o[11:8]), alpha)),
               4'(blend_ch(int'(col[7:4]),  int'(o[7:4]),  alpha)),
               4'(blend_ch(int'(col[3:0]),  int'(o[3:0]),  alpha))};
        end
        exp_wr.push_back('{a, p});
        ref_mem[a] = p;
      end
    end
  endtask

  // ---------------- VRAM controller model ----------------
  int rd_wait = -1, wr_wait = -1, since = -1, wr_force_lat = -1;
  bit spur_en = 1'b0;
  logic [ADDR_W-1:0]  rd_addr_l, wr_addr_l;
  logic [PIXEL_W-1:0] wr_data_l;

  initial begin : vram_model
    wr_t w;
    vif.i_vram_read_data       = '0;
    vif.i_vram_read_data_valid = 1'b0;
    vif.i_vram_write_done      = 1'b0;
    forever begin
      @(negedge clk);
      vif.i_vram_read_data_valid = 1'b0;
      vif.i_vram_write_done      = 1'b0;
      if (since >= 0) since++;
      if (vif.o_vram_read_request) begin
        if (rd_wait < 0) begin
          if (since >= 0) check_eq("req_gap", since, 2);
          since     = -1;
          rd_addr_l = vif.o_vram_read_address;
          check_eq("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) check_eq("rd_addr", rd_addr_l, exp_rd.pop_front());
          rd_wait = $urandom_range(0, 3);
        end else begin
          check_eq("rd_addr_stable", vif.o_vram_read_address, rd_addr_l);
          if (rd_wait == 0) begin
            vif.i_vram_read_data_valid = 1'b1;
            vif.i_vram_read_data       = vram_get(int'(rd_addr_l));
            rd_wait = -1;
            since   = 0;
          end else rd_wait--;
        end
      end else begin
        rd_wait = -1;
        if (spur_en && $urandom_range(0, 3) == 0) begin
          vif.i_vram_read_data_valid = 1'b1;
          vif.i_vram_read_data       = 12'($urandom);
        end
      end
      if (vif.o_vram_write_request) begin
        if (wr_wait < 0) begin
          if (since >= 0) check_eq("req_gap", since, 2);
          since     = -1;
          wr_addr_l = vif.o_vram_write_address;
          wr_data_l = vif.o_vram_write_data;
          check_eq("wr_expected", exp_wr.size() > 0, 1);
          if (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            check_eq("wr_addr", wr_addr_l, w.addr);
            check_eq("wr_data", wr_data_l, w.data);
          end
          wr_wait = (wr_force_lat >= 0) ? wr_force_lat : int'($urandom_range(0, 3));
        end else begin
          check_eq("wr_addr_stable", vif.o_vram_write_address, wr_addr_l);
          check_eq("wr_data_stable", vif.o_vram_write_data, wr_data_l);
          if (wr_wait == 0) begin
            vif.i_vram_write_done = 1'b1;
            vram_mem[int'(wr_addr_l)] = wr_data_l;
            wr_wait = -1;
            since   = 0;
          end else wr_wait--;
        end
      end else begin
        wr_wait = -1;
        if (spur_en && $urandom_range(0, 3) == 0) vif.i_vram_write_done = 1'b1;
      end
    end
  end

  // ---------------- command driver ----------------
  task automatic scramble();
    cx1 = 10'($urandom); cx2 = 10'($urandom); cy1 = 10'($urandom); cy2 = 10'($urandom);
    cr = 4'($urandom); cg = 4'($urandom); cb = 4'($urandom); ca = 4'($urandom);
    bank = 1'($urandom);
  endtask

  task automatic drive_cmd(input int x1, input int x2, input int y1, input int y2,
                           input bit bnk, input logic [11:0] col, input int alpha);
    since = -1;
    cx1 = 10'(x1); cx2 = 10'(x2); cy1 = 10'(y1); cy2 = 10'(y2);
    cr = col[11:8]; cg = col[7:4]; cb = col[3:0]; ca = 4'(alpha);
    bank  = bnk;
    start = 1'b1;
  endtask

  task automatic run_cmd(input int x1, input int x2, input int y1, input int y2,
                         input bit bnk, input logic [11:0] col, input int alpha,
                         input bit poke_start, input int exp_lat, input string name);
    int cycles;
    model_cmd(x1, x2, y1, y2, bnk, col, alpha);
    @(negedge clk);
    drive_cmd(x1, x2, y1, y2, bnk, col, alpha);
    @(negedge clk);
    start = 1'b0;
    scramble();
    check_eq({name, "_busy"}, busy, 1);
    cycles = 1;
    while (!finished && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      start = poke_start && (cycles == 3);
    end
    start = 1'b0;
    check_eq({name, "_finished"}, finished, 1);
    if (exp_lat > 0) check_eq({name, "_latency"}, cycles, exp_lat);
    check_eq({name, "_busy_end"}, busy, 0);
    check_eq({name, "_writes_left"}, exp_wr.size(), 0);
    check_eq({name, "_reads_left"}, exp_rd.size(), 0);
    @(negedge clk);
    check_eq({name, "_single_pulse"}, finished, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int  cycles;
    bit  fin_seen;
    rst = 1'b1;
    start = 1'b0;
    cx1 = '0; cx2 = '0; cy1 = '0; cy2 = '0;
    cr = '0; cg = '0; cb = '0; ca = '0; bank = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_finished", finished, 0);
    check_eq("rst_rd_req", vif.o_vram_read_request, 0);
    check_eq("rst_wr_req", vif.o_vram_write_request, 0);
    check_eq("rst_rd_addr", vif.o_vram_read_address, 0);
    check_eq("rst_wr_addr", vif.o_vram_write_address, 0);
    check_eq("rst_wr_data", vif.o_vram_write_data, 0);
    rst = 1'b0;

    // fill 3x2 in bank 0
    run_cmd(2, 4, 1, 2, 1'b0, 12'hABC, 15, 1'b0, 0, "fill");
    check_eq("fill_px482", vram_get(482), 12'hABC);
    check_eq("fill_px964", vram_get(964), 12'hABC);

    // single-pixel blend against a known background
    vram_mem[0] = 12'h0F0;
    ref_mem[0]  = 12'h0F0;
    run_cmd(0, 0, 0, 0, 1'b0, 12'hF00, 8, 1'b0, 0, "blend");
    check_eq("blend_px0", vram_get(0), 12'h870);

    // bank 1 base
    run_cmd(0, 0, 0, 0, 1'b1, 12'h35C, 15, 1'b0, 0, "bank1");
    check_eq("bank1_px", vram_get(BANK1), 12'h35C);

    // empty rectangle
    run_cmd(5, 3, 0, 0, 1'b0, 12'h111, 15, 1'b0, 2, "empty_x");
    run_cmd(0, 0, 7, 6, 1'b0, 12'h111, 3, 1'b0, 2, "empty_y");

    // start pulsed while busy must be ignored
    run_cmd(10, 13, 5, 6, 1'b0, 12'h5A3, 15, 1'b1, 0, "poke");

    // slow write completion
    wr_force_lat = 9;
    run_cmd(20, 21, 3, 3, 1'b0, 12'h9C1, 5, 1'b0, 0, "slow_wr");
    wr_force_lat = -1;

    // alpha 0 keeps the background; corner at max coordinates
    run_cmd(30, 32, 2, 2, 1'b1, 12'hFFF, 0, 1'b0, 0, "alpha0");
    run_cmd(1022, 1023, 1022, 1023, 1'b0, 12'h7E2, 15, 1'b0, 0, "maxcoord");

`ifdef RENDERER_CLIP_EN
    run_cmd(478, 600, 0, 0, 1'b0, 12'h2B4, 15, 1'b0, 0, "clip_edge");
    check_eq("clip_px479", vram_get(479), 12'h2B4);
    run_cmd(500, 510, 0, 0, 1'b0, 12'h2B4, 15, 1'b0, 2, "clip_out");
`endif

    // reset while a write request is pending
    model_cmd(40, 43, 10, 10, 1'b0, 12'h123, 15);
    wr_force_lat = 20;
    @(negedge clk);
    drive_cmd(40, 43, 10, 10, 1'b0, 12'h123, 15);
    @(negedge clk);
    start  = 1'b0;
    cycles = 0;
    while (!vif.o_vram_write_request && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check_eq("rst_mid_wr_req_seen", vif.o_vram_write_request, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_wr_req", vif.o_vram_write_request, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_finished", finished, 0);
    rst = 1'b0;
    fin_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (finished) fin_seen = 1'b1;
    end
    check_eq("rst_mid_no_finish", fin_seen, 0);
    wr_force_lat = -1;
    exp_wr.delete();
    exp_rd.delete();
    ref_mem = vram_mem;
    run_cmd(50, 51, 11, 11, 1'b0, 12'h456, 15, 1'b0, 0, "after_rst");

    // randomized commands with spurious strobes
    spur_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int x1, x2, y1, y2, al;
      bit bk, pk;
      logic [11:0] col;
      x1 = $urandom_range(0, 1023);
      x2 = x1 + $urandom_range(0, 3);
      if (x2 > 1023) x2 = 1023;
      y1 = $urandom_range(0, 1023);
      y2 = y1 + $urandom_range(0, 2);
      if (y2 > 1023) y2 = 1023;
      if ($urandom_range(0, 7) == 0 && x1 > 0) x2 = x1 - 1;
      al  = ($urandom_range(0, 2) == 0) ? 15 : int'($urandom_range(0, 15));
      bk  = 1'($urandom_range(0, 1));
      pk  = 1'($urandom_range(0, 1));
      col = 12'($urandom);
      run_cmd(x1, x2, y1, y2, bk, col, al, pk, (x2 < x1) ? 2 : 0, "rnd");
    end
    spur_en = 1'b0;

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
